// File: rtl/sa_autosa_rdma_grp_regfile_if.sv
// CSB register bus between the host register interface and the RDMA group
// register file: one write per cycle, zero-latency combinational read data.
interface sa_autosa_rdma_grp_regfile_if;
    logic [11:0] reg_offset;
    logic [31:0] reg_wr_data;
    logic        reg_wr_en;
    logic [31:0] reg_rd_data;

    modport master (
        output reg_offset,
        output reg_wr_data,
        output reg_wr_en,
        input  reg_rd_data
    );

    modport slave (
        input  reg_offset,
        input  reg_wr_data,
        input  reg_wr_en,
        output reg_rd_data
    );
endinterface

// File: rtl/sa_autosa_rdma_grp_regfile.sv
// RDMA ping-pong configuration register groups.
// Software programs the group selected by "producer" and arms it through
// OP_ENABLE; the read engine executes the group selected by "consumer" and
// retires it with op_done. Each group walks IDLE -> ARMED -> RUNNING -> IDLE.
// Illegal requests are dropped and raise a sticky err flag.
module sa_autosa_rdma_grp_regfile #(
    parameter int          NUM_GRP    = 2,
    parameter int          NUM_CFG    = 4,
    parameter logic [11:0] GRP_BASE   = 12'h100,
    parameter logic [11:0] GRP_STRIDE = 12'h040,
    parameter bit          AUTO_PROD  = 1'b1,
    localparam int         PTR_W      = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1
) (
    input  logic                         autosa_core_clk,
    input  logic                         autosa_core_rstn,
    sa_autosa_rdma_grp_regfile_if.slave  csb,
    output logic [PTR_W-1:0]             producer,
    input  logic [PTR_W-1:0]             consumer,
    input  logic                         op_done,
    output logic [NUM_GRP-1:0]           op_en,
    output logic [32*NUM_CFG-1:0]        cfg_active,
    output logic                         err
);

    localparam logic [11:0] ADDR_STATUS  = 12'h000;
    localparam logic [11:0] ADDR_POINTER = 12'h004;
    localparam logic [11:0] ADDR_ERR_CLR = 12'h008;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } grp_state_t;

    // Byte offset of slot "slot" inside group "g": slot 0 is OP_ENABLE,
    // slot k+1 is CFG word k.
    function automatic logic [11:0] grp_addr(input int g, input int slot);
        return GRP_BASE + 12'(g) * GRP_STRIDE + 12'(4 * slot);
    endfunction

    grp_state_t                          state [NUM_GRP];
    logic [NUM_GRP-1:0][NUM_CFG-1:0][31:0] cfg_mem;

    logic                                wr_bit;
    logic                                ptr_wr;
    logic                                ptr_ok;
    logic                                clr_wr;
    logic [NUM_GRP-1:0]                  en_wr;
    logic [NUM_GRP-1:0][NUM_CFG-1:0]     cfg_wr;
    logic [NUM_GRP-1:0]                  arm_ok;
    logic                                cons_run;
    logic                                adv;
    logic                                err_set;
    logic [PTR_W-1:0]                    prod_inc;

    assign wr_bit = csb.reg_wr_data[0];
    // The whole low half-word is the requested producer value, so an
    // out-of-range write is caught even when its low PTR_W bits look legal.
    assign ptr_ok = (csb.reg_wr_data[15:0] < 16'(NUM_GRP));
    assign prod_inc = (int'(producer) == NUM_GRP - 1) ? '0 : producer + PTR_W'(1);

    // Address decode of the single write strobe into per-register write hits.
    always_comb begin
        ptr_wr = csb.reg_wr_en && (csb.reg_offset == ADDR_POINTER);
        clr_wr = csb.reg_wr_en && (csb.reg_offset == ADDR_ERR_CLR);
        en_wr  = '0;
        cfg_wr = '0;
        for (int g = 0; g < NUM_GRP; g++) begin
            en_wr[g] = csb.reg_wr_en && (csb.reg_offset == grp_addr(g, 0));
            for (int k = 0; k < NUM_CFG; k++) begin
                cfg_wr[g][k] = csb.reg_wr_en && (csb.reg_offset == grp_addr(g, k + 1));
            end
        end
    end

    // Legality of this cycle's requests, judged against the pre-cycle state.
    always_comb begin
        arm_ok   = '0;
        err_set  = 1'b0;
        cons_run = 1'b0;
        adv      = 1'b0;
        for (int g = 0; g < NUM_GRP; g++) begin
            arm_ok[g] = en_wr[g] && wr_bit && (state[g] == ST_IDLE);
            if (en_wr[g] && wr_bit && (state[g] != ST_IDLE)) begin
                err_set = 1'b1;
            end
            if (en_wr[g] && !wr_bit && (state[g] == ST_RUN)) begin
                err_set = 1'b1;
            end
            if ((|cfg_wr[g]) && (state[g] != ST_IDLE)) begin
                err_set = 1'b1;
            end
            if ((consumer == PTR_W'(g)) && (state[g] == ST_RUN)) begin
                cons_run = 1'b1;
            end
            if (AUTO_PROD && (producer == PTR_W'(g)) && arm_ok[g]) begin
                adv = 1'b1;
            end
        end
        if (ptr_wr && !ptr_ok) begin
            err_set = 1'b1;
        end
        if (op_done && !cons_run) begin
            err_set = 1'b1;
        end
    end

    // Per-group lifecycle; op_en is registered alongside the state it mirrors.
    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            for (int g = 0; g < NUM_GRP; g++) begin
                state[g] <= ST_IDLE;
            end
            op_en <= '0;
        end else begin
            for (int g = 0; g < NUM_GRP; g++) begin
                case (state[g])
                    ST_IDLE: begin
                        if (arm_ok[g]) begin
                            state[g] <= ST_ARMED;
                            op_en[g] <= 1'b1;
                        end
                    end
                    ST_ARMED: begin
                        // A cancel is honoured even if the engine reaches
                        // this group in the same cycle.
                        if (en_wr[g] && !wr_bit) begin
                            state[g] <= ST_IDLE;
                            op_en[g] <= 1'b0;
                        end else if (consumer == PTR_W'(g)) begin
                            state[g] <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (op_done && (consumer == PTR_W'(g))) begin
                            state[g] <= ST_IDLE;
                            op_en[g] <= 1'b0;
                        end
                    end
                    default: begin
                        state[g] <= ST_IDLE;
                        op_en[g] <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Config word storage; only an IDLE group accepts new words.
    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            cfg_mem <= '0;
        end else begin
            for (int g = 0; g < NUM_GRP; g++) begin
                for (int k = 0; k < NUM_CFG; k++) begin
                    if (cfg_wr[g][k] && (state[g] == ST_IDLE)) begin
                        cfg_mem[g][k] <= csb.reg_wr_data;
                    end
                end
            end
        end
    end

    // Producer pointer: an explicit legal write beats auto-advance.
    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            producer <= '0;
        end else if (ptr_wr && ptr_ok) begin
            producer <= csb.reg_wr_data[PTR_W-1:0];
        end else if (adv) begin
            producer <= prod_inc;
        end
    end

    // Sticky error flag; a new error in the clearing cycle keeps it set.
    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            err <= 1'b0;
        end else if (err_set) begin
            err <= 1'b1;
        end else if (clr_wr && wr_bit) begin
            err <= 1'b0;
        end
    end

    // Config words of the group the engine is on; no group selects zeros.
    always_comb begin
        cfg_active = '0;
        for (int g = 0; g < NUM_GRP; g++) begin
            if (consumer == PTR_W'(g)) begin
                cfg_active = cfg_mem[g];
            end
        end
    end

    // Zero-latency register read mux; unmapped offsets read as zero.
    always_comb begin
        csb.reg_rd_data = '0;
        if (csb.reg_offset == ADDR_STATUS) begin
            for (int g = 0; g < NUM_GRP; g++) begin
                csb.reg_rd_data[2*g +: 2] = state[g];
            end
            csb.reg_rd_data[31] = err;
        end else if (csb.reg_offset == ADDR_POINTER) begin
            csb.reg_rd_data[PTR_W-1:0]  = producer;
            csb.reg_rd_data[16 +: PTR_W] = consumer;
        end else begin
            for (int g = 0; g < NUM_GRP; g++) begin
                if (csb.reg_offset == grp_addr(g, 0)) begin
                    csb.reg_rd_data[0] = (state[g] != ST_IDLE);
                end
                for (int k = 0; k < NUM_CFG; k++) begin
                    if (csb.reg_offset == grp_addr(g, k + 1)) begin
                        csb.reg_rd_data = cfg_mem[g][k];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sa_autosa_rdma_grp_regfile.sv
// Directed bench for the RDMA group register file (NUM_GRP=2, NUM_CFG=4).
module tb_sa_autosa_rdma_grp_regfile;

    logic         clk;
    logic         rstn;
    logic [0:0]   producer;
    logic [0:0]   consumer;
    logic         op_done;
    logic [1:0]   op_en;
    logic [127:0] cfg_active;
    logic         err;

    int n_cmp = 0;
    int n_bad = 0;

    sa_autosa_rdma_grp_regfile_if csb_bus();

    sa_autosa_rdma_grp_regfile dut (
        .autosa_core_clk  (clk),
        .autosa_core_rstn (rstn),
        .csb              (csb_bus),
        .producer         (producer),
        .consumer         (consumer),
        .op_done          (op_done),
        .op_en            (op_en),
        .cfg_active       (cfg_active),
        .err              (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1 ns after the rising edge, well away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_wr(input logic [11:0] addr, input logic [31:0] data);
        csb_bus.reg_offset  = addr;
        csb_bus.reg_wr_data = data;
        csb_bus.reg_wr_en   = 1'b1;
        tick();
        csb_bus.reg_wr_en   = 1'b0;
    endtask

    task automatic reg_rd(input logic [11:0] addr, output logic [31:0] data);
        csb_bus.reg_offset = addr;
        #1;
        data = csb_bus.reg_rd_data;
    endtask

    task automatic pulse_done();
        op_done = 1'b1;
        tick();
        op_done = 1'b0;
    endtask

    logic [31:0] rd;

    initial begin
        rstn                = 1'b0;
        consumer            = 1'b0;
        op_done             = 1'b0;
        csb_bus.reg_offset  = 12'h000;
        csb_bus.reg_wr_data = 32'h0;
        csb_bus.reg_wr_en   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        tick();

        // Reset state
        reg_rd(12'h000, rd); check_val("rst_status", rd, 32'h0);
        reg_rd(12'h004, rd); check_val("rst_pointer", rd, 32'h0);
        reg_rd(12'h144, rd); check_val("rst_g1_cfg0", rd, 32'h0);
        check_val("rst_op_en", 32'(op_en), 32'h0);
        check_val("rst_err", 32'(err), 32'h0);
        check_val("rst_cfg_active", cfg_active[31:0], 32'h0);

        // Program and arm group 0 (producer advances 0 -> 1)
        reg_wr(12'h104, 32'hDEADBEEF);
        reg_wr(12'h100, 32'h1);
        reg_rd(12'h000, rd); check_val("arm_status", rd, 32'h1);
        check_val("arm_op_en", 32'(op_en), 32'h1);
        check_val("arm_producer", 32'(producer), 32'h1);
        reg_rd(12'h100, rd); check_val("arm_opena_rd", rd, 32'h1);
        tick();
        reg_rd(12'h000, rd); check_val("run_status", rd, 32'h2);
        check_val("run_cfg_active", cfg_active[31:0], 32'hDEADBEEF);

        // CFG write to a RUNNING group is dropped and flags err
        reg_wr(12'h104, 32'h00001234);
        reg_rd(12'h104, rd); check_val("locked_cfg0", rd, 32'hDEADBEEF);
        check_val("locked_err", 32'(err), 32'h1);
        reg_rd(12'h000, rd); check_val("locked_status", rd, 32'h80000002);
        reg_wr(12'h008, 32'h1);
        check_val("errclr_err", 32'(err), 32'h0);
        reg_rd(12'h008, rd); check_val("errclr_rd", rd, 32'h0);

        // Retire group 0, then arm 0 (not producer) and 1 (producer wraps)
        pulse_done();
        reg_rd(12'h000, rd); check_val("done_status", rd, 32'h0);
        check_val("done_err", 32'(err), 32'h0);
        reg_wr(12'h100, 32'h1);
        check_val("arm_nonprod_producer", 32'(producer), 32'h1);
        reg_wr(12'h140, 32'h1);
        reg_rd(12'h000, rd); check_val("two_armed_status", rd, 32'h6);
        check_val("wrap_producer", 32'(producer), 32'h0);
        pulse_done();
        reg_rd(12'h000, rd); check_val("g0_retired_status", rd, 32'h4);
        consumer = 1'b1;
        tick();
        reg_rd(12'h000, rd); check_val("g1_run_status", rd, 32'h8);
        check_val("g1_run_op_en", 32'(op_en), 32'h2);
        check_val("g1_run_err", 32'(err), 32'h0);

        // op_done and re-arm of the same RUNNING group in one cycle
        op_done = 1'b1;
        reg_wr(12'h140, 32'h1);
        op_done = 1'b0;
        reg_rd(12'h000, rd); check_val("coll_status", rd, 32'h80000000);
        check_val("coll_op_en", 32'(op_en), 32'h0);
        check_val("coll_producer", 32'(producer), 32'h0);
        reg_wr(12'h008, 32'h1);
        check_val("coll_clr_err", 32'(err), 32'h0);

        // op_done with the consumer group idle
        pulse_done();
        check_val("stray_done_err", 32'(err), 32'h1);
        reg_wr(12'h008, 32'h1);

        // Arm then cancel group 1 while the engine is on group 0
        consumer = 1'b0;
        reg_wr(12'h140, 32'h1);
        reg_rd(12'h000, rd); check_val("g1_armed_status", rd, 32'h4);
        reg_wr(12'h140, 32'h0);
        reg_rd(12'h000, rd); check_val("cancel_status", rd, 32'h0);
        check_val("cancel_err", 32'(err), 32'h0);

        // Pointer writes: out of range rejected, legal value taken
        reg_wr(12'h004, 32'h5);
        check_val("badptr_producer", 32'(producer), 32'h0);
        check_val("badptr_err", 32'(err), 32'h1);
        reg_wr(12'h004, 32'h1);
        reg_rd(12'h004, rd); check_val("ptr_rd", rd, 32'h1);
        reg_wr(12'h008, 32'h1);
        reg_rd(12'h0FC, rd); check_val("unmapped_rd", rd, 32'h0);

        // Asynchronous reset while group 0 is RUNNING
        reg_wr(12'h104, 32'hCAFEF00D);
        reg_wr(12'h100, 32'h1);
        tick();
        reg_rd(12'h000, rd); check_val("pre_rst_status", rd, 32'h2);
        check_val("pre_rst_cfg_active", cfg_active[31:0], 32'hCAFEF00D);
        rstn = 1'b0;
        #1;
        check_val("arst_op_en", 32'(op_en), 32'h0);
        check_val("arst_producer", 32'(producer), 32'h0);
        check_val("arst_cfg_active", cfg_active[31:0], 32'h0);
        reg_rd(12'h000, rd); check_val("arst_status", rd, 32'h0);
        reg_rd(12'h104, rd); check_val("arst_cfg0", rd, 32'h0);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
